// File: rtl/sdram_cmd_pkg.sv
// Shared types and entry layout for the SDRAM command queue.
package sdram_cmd_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 24;
    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned DEPTH_LOG2_DEF = 2;

    // Entry layout (MSB..LSB): {we, addr, data}
    localparam int unsigned ENTRY_WIDTH = 1 + ADDR_WIDTH_DEF + DATA_WIDTH_DEF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

    function automatic int unsigned entry_width(int unsigned aw, int unsigned dw);
        return 1 + aw + dw;
    endfunction

    // Data occupies the low bits, so the address slice starts right above it.
    function automatic int unsigned addr_lsb(int unsigned dw);
        return dw;
    endfunction

    function automatic int unsigned we_bit(int unsigned aw, int unsigned dw);
        return aw + dw;
    endfunction

endpackage

// File: rtl/sdram_cmd_queue_if.sv
// Host-side request/response bus of the SDRAM command queue.
interface sdram_cmd_queue_if
    import sdram_cmd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [ADDR_WIDTH-1:0] rsp_addr;

    modport master (
        output req_valid, req_we, req_addr, req_data,
        input  req_ready, rsp_valid, rsp_data, rsp_addr
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_data,
        output req_ready, rsp_valid, rsp_data, rsp_addr
    );

endinterface

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, 2**DEPTH_LOG2 entries, extra-MSB pointers.
module sync_fifo
    import sdram_cmd_pkg::*;
#(
    parameter int unsigned WIDTH      = ENTRY_WIDTH,
    parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   level_o
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Status is derived from registered pointers only.
    assign full_o  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[PTR_W-2:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next pointer values; wrap is natural modulo 2**PTR_W.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-2:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/sdram_cmd_queue.sv
// Buffers host requests and issues them one at a time to sdram_controller.
module sdram_cmd_queue
    import sdram_cmd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    sdram_cmd_queue_if.slave      host,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  idle_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  wr_enable_o,
    output logic                  rd_enable_o,
    input  logic                  busy_i,
    input  logic                  rd_ready_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i
);

    localparam int unsigned ENTRY_W  = entry_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int unsigned ADDR_LSB = addr_lsb(DATA_WIDTH);
    localparam int unsigned WE_BIT   = we_bit(ADDR_WIDTH, DATA_WIDTH);

    logic [ENTRY_W-1:0]    push_entry;
    logic [ENTRY_W-1:0]    head_entry;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop_c;

    logic                  head_we;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;

    state_e                state_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  wr_en_q;
    logic                  rd_en_q;
    logic                  rd_got_q;
    logic [DATA_WIDTH-1:0] rd_cap_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic [ADDR_WIDTH-1:0] rsp_addr_q;

    assign push_entry = {host.req_we, host.req_addr, host.req_data};

    assign head_we   = head_entry[WE_BIT];
    assign head_addr = head_entry[ADDR_LSB +: ADDR_WIDTH];
    assign head_data = head_entry[DATA_WIDTH-1:0];

    // A new transaction starts only when the controller is free.
    assign pop_c = (state_q == IDLE) && !fifo_empty && !busy_i;

    sync_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (host.req_valid),
        .wdata_i (push_entry),
        .pop_i   (pop_c),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    // Transaction FSM with registered controller and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_got_q    <= 1'b0;
            rd_cap_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_addr_q  <= '0;
        end else begin
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pop_c) begin
                        we_q     <= head_we;
                        addr_q   <= head_addr;
                        data_q   <= head_data;
                        rd_got_q <= 1'b0;
                        wr_en_q  <= head_we;
                        rd_en_q  <= !head_we;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    // The controller may return read data before raising busy.
                    if (!we_q && rd_ready_i) begin
                        rd_cap_q <= rd_data_i;
                        rd_got_q <= 1'b1;
                    end
                    if (busy_i) begin
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (we_q) begin
                        if (!busy_i) begin
                            state_q <= IDLE;
                        end
                    end else begin
                        if (rd_ready_i && !rd_got_q) begin
                            rd_cap_q <= rd_data_i;
                            rd_got_q <= 1'b1;
                        end
                        if (!busy_i && (rd_got_q || rd_ready_i)) begin
                            state_q     <= IDLE;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= rd_got_q ? rd_cap_q : rd_data_i;
                            rsp_addr_q  <= addr_q;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign host.req_ready = !fifo_full;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_data  = rsp_data_q;
    assign host.rsp_addr  = rsp_addr_q;

    assign idle_o      = fifo_empty && (state_q == IDLE);
    assign addr_o      = addr_q;
    assign wr_data_o   = data_q;
    assign wr_enable_o = wr_en_q;
    assign rd_enable_o = rd_en_q;

endmodule

// File: tb/tb_sdram_cmd_queue.sv
// Scoreboard bench for sdram_cmd_queue with a simple controller model.
module tb_sdram_cmd_queue;

    localparam int unsigned AW  = 24;
    localparam int unsigned DW  = 16;
    localparam int unsigned DL2 = 2;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } iss_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DL2:0]  level;
    logic          idle;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic          rd_en;
    logic          busy;
    logic          rd_ready;
    logic [DW-1:0] rd_data;

    sdram_cmd_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) host ();

    sdram_cmd_queue #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH_LOG2 (DL2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .host        (host),
        .level_o     (level),
        .idle_o      (idle),
        .addr_o      (addr),
        .wr_data_o   (wr_data),
        .wr_enable_o (wr_en),
        .rd_enable_o (rd_en),
        .busy_i      (busy),
        .rd_ready_i  (rd_ready),
        .rd_data_i   (rd_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rsp_seen = 0;
    int rsp_expected = 0;
    int acc_level = 0;

    iss_t iss_q[$];
    rsp_t rsp_q[$];
    logic [DW-1:0] exp_mem [16];
    logic [DW-1:0] sdram   [16];

    // controller model configuration
    int cfg_lat  = 1;
    int cfg_hold = 6;
    bit cfg_rand = 1'b0;
    bit cfg_early = 1'b0;
    bit hold_busy = 1'b0;

    bit            m_act = 1'b0;
    int            m_cnt = 0;
    int            m_lat = 1;
    int            m_hold = 1;
    bit            m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Controller model: busy after m_lat cycles for m_hold cycles, one rd_ready pulse per read.
    initial begin
        busy = 1'b0; rd_ready = 1'b0; rd_data = 16'hDEAD;
        forever begin
            @(posedge clk); #1;
            rd_ready = 1'b0;
            rd_data  = 16'hDEAD;
            if (rst) begin
                m_act = 1'b0;
                busy  = 1'b0;
            end else if (!m_act) begin
                busy = hold_busy;
                if (wr_en || rd_en) begin
                    m_act  = 1'b1;
                    m_cnt  = 0;
                    m_we   = wr_en;
                    m_addr = addr;
                    m_lat  = cfg_rand ? int'($urandom_range(3, 1)) : cfg_lat;
                    m_hold = cfg_rand ? int'($urandom_range(8, 2)) : cfg_hold;
                    if (wr_en) sdram[addr[3:0]] = wr_data;
                end
            end else begin
                m_cnt++;
                busy = ((m_cnt >= m_lat) && (m_cnt < m_lat + m_hold)) || hold_busy;
                if (!m_we && (m_cnt == (cfg_early ? 1 : m_lat + m_hold - 1))) begin
                    rd_ready = 1'b1;
                    rd_data  = sdram[m_addr[3:0]];
                end
                if (m_cnt >= m_lat + m_hold) m_act = 1'b0;
            end
        end
    end

    // Issue monitor: checks controller commands against pushed order.
    initial begin
        bit   prev_en;
        bit   prev_busy;
        bit   cur_v;
        int   last_iss;
        iss_t cur;
        prev_en = 1'b0; prev_busy = 1'b0; cur_v = 1'b0; last_iss = -1; cur = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_en  = 1'b0;
                cur_v    = 1'b0;
                last_iss = -1;
            end else begin
                if (wr_en || rd_en) begin
                    chk("en_exclusive", 64'(wr_en & rd_en), 64'd0);
                    chk("en_one_cycle", 64'(prev_en), 64'd0);
                    chk("issue_when_not_busy", 64'(prev_busy), 64'd0);
                    if (last_iss >= 0) chk("issue_spacing", 64'(cyc - last_iss >= 4), 64'd1);
                    last_iss = cyc;
                    if (iss_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_issue: we=%0b addr=0x%0h with nothing expected", wr_en, addr);
                    end else begin
                        cur = iss_q.pop_front();
                        cur_v = 1'b1;
                        chk("issue_we", 64'(wr_en), 64'(cur.we));
                        chk("issue_addr", 64'(addr), 64'(cur.addr));
                        if (cur.we) chk("issue_wdata", 64'(wr_data), 64'(cur.data));
                    end
                end else if (cur_v && m_act) begin
                    chk("addr_stable", 64'(addr), 64'(cur.addr));
                    if (cur.we) chk("wdata_stable", 64'(wr_data), 64'(cur.data));
                end
                prev_en = wr_en | rd_en;
            end
            prev_busy = busy;
        end
    end

    // Response monitor: pops the scoreboard on every rsp_valid pulse.
    initial begin
        bit   prev_rsp;
        rsp_t r;
        prev_rsp = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && host.rsp_valid) begin
                rsp_seen++;
                chk("rsp_one_cycle", 64'(prev_rsp), 64'd0);
                if (rsp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp: addr=0x%0h data=0x%0h with nothing expected",
                             host.rsp_addr, host.rsp_data);
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp_addr", 64'(host.rsp_addr), 64'(r.addr));
                    chk("rsp_data", 64'(host.rsp_data), 64'(r.data));
                end
            end
            prev_rsp = rst ? 1'b0 : host.rsp_valid;
        end
    end

    task automatic push(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int   n;
        iss_t e;
        rsp_t r;
        n = 0;
        host.req_valid = 1'b1;
        host.req_we    = we;
        host.req_addr  = a;
        host.req_data  = d;
        while (!host.req_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!host.req_ready) begin
            checks++; errors++;
            $display("FAIL push_timeout: req_ready stayed 0 for addr 0x%0h", a);
        end else begin
            acc_level = int'(level);
            e.we = we; e.addr = a; e.data = d;
            iss_q.push_back(e);
            if (we) begin
                exp_mem[a[3:0]] = d;
            end else begin
                r.addr = a; r.data = exp_mem[a[3:0]];
                rsp_q.push_back(r);
                rsp_expected++;
            end
        end
        @(negedge clk);
        host.req_valid = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        int n;
        n = 0;
        while (!(iss_q.size() == 0 && rsp_q.size() == 0 && idle && !m_act && !host.rsp_valid)
               && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL %s: queue not drained, iss=%0d rsp=%0d idle=%0b", name,
                     iss_q.size(), rsp_q.size(), idle);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 16; i++) begin
            exp_mem[i] = '0;
            sdram[i]   = '0;
        end
        rst = 1'b1;
        host.req_valid = 1'b0; host.req_we = 1'b0; host.req_addr = '0; host.req_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_ready", 64'(host.req_ready), 64'd1);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_enables", 64'({wr_en, rd_en}), 64'd0);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_wdata", 64'(wr_data), 64'd0);
        chk("rst_rsp_valid", 64'(host.rsp_valid), 64'd0);

        // single write
        cfg_lat = 1; cfg_hold = 6;
        push(1'b1, 24'h000005, 16'hA5A5);
        chk("w1_level", 64'(level), 64'd1);
        chk("w1_not_idle", 64'(idle), 64'd0);
        wait_quiet("w1_drain");
        chk("w1_idle_after", 64'(idle), 64'd1);
        chk("w1_addr_held", 64'(addr), 64'h5);
        chk("w1_wdata_held", 64'(wr_data), 64'hA5A5);
        chk("w1_sdram", 64'(sdram[5]), 64'hA5A5);

        // write then read same address
        push(1'b1, 24'h000003, 16'h1234);
        push(1'b0, 24'h000003, 16'h0000);
        wait_quiet("wr_drain");
        chk("wr_rsp_data_held", 64'(host.rsp_data), 64'h1234);
        chk("wr_rsp_addr_held", 64'(host.rsp_addr), 64'h3);
        chk("wr_rsp_count", 64'(rsp_seen), 64'd1);

        // fill to full while the controller is busy
        hold_busy = 1'b1;
        repeat (2) @(negedge clk);
        push(1'b1, 24'h00000A, 16'h0A0A);
        push(1'b0, 24'h00000A, 16'h0000);
        push(1'b1, 24'h00000B, 16'h0B0B);
        push(1'b0, 24'h00000B, 16'h0000);
        chk("full_level", 64'(level), 64'd4);
        chk("full_ready", 64'(host.req_ready), 64'd0);
        host.req_valid = 1'b1; host.req_we = 1'b1; host.req_addr = 24'h00000C; host.req_data = 16'h0C0C;
        @(negedge clk);
        chk("full_5th_blocked", 64'(host.req_ready), 64'd0);
        chk("full_level_held", 64'(level), 64'd4);
        hold_busy = 1'b0;
        push(1'b1, 24'h00000C, 16'h0C0C);
        chk("full_5th_at_level3", 64'(acc_level), 64'd3);
        wait_quiet("full_drain");
        chk("full_sdram_c", 64'(sdram[12]), 64'h0C0C);

        // pointer wrap with random controller latency
        cfg_rand = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if ((i % 2) == 0) push(1'b1, 24'(i), 16'(16'h1000 + 16'(i) * 16'h0111));
            else              push(1'b0, 24'(i - 1), 16'h0000);
        end
        wait_quiet("wrap_drain");
        cfg_rand = 1'b0;
        chk("wrap_rsp_count", 64'(rsp_seen), 64'd8);

        // reset in the middle of a read
        cfg_lat = 1; cfg_hold = 10;
        push(1'b0, 24'h000003, 16'h0000);
        push(1'b0, 24'h000005, 16'h0000);
        push(1'b0, 24'h000003, 16'h0000);
        n = 0;
        while (!busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mid_busy_seen", 64'(busy), 64'd1);
        @(negedge clk);
        chk("mid_level", 64'(level), 64'd2);
        rst = 1'b1;
        rsp_expected -= rsp_q.size();
        iss_q.delete();
        rsp_q.delete();
        #1;
        chk("arst_level", 64'(level), 64'd0);
        chk("arst_ready", 64'(host.req_ready), 64'd1);
        chk("arst_idle", 64'(idle), 64'd1);
        chk("arst_enables", 64'({wr_en, rd_en}), 64'd0);
        chk("arst_addr", 64'(addr), 64'd0);
        chk("arst_wdata", 64'(wr_data), 64'd0);
        chk("arst_rsp_valid", 64'(host.rsp_valid), 64'd0);
        chk("arst_rsp_data", 64'(host.rsp_data), 64'd0);
        chk("arst_rsp_addr", 64'(host.rsp_addr), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        cfg_lat = 1; cfg_hold = 4;
        push(1'b0, 24'h000003, 16'h0000);
        wait_quiet("post_rst_drain");
        chk("post_rst_rsp_data", 64'(host.rsp_data), 64'h1234);

        // rd_ready arriving before busy rises
        cfg_lat = 2; cfg_hold = 3; cfg_early = 1'b1;
        push(1'b1, 24'h000008, 16'hBEEF);
        push(1'b0, 24'h000008, 16'h0000);
        wait_quiet("early_drain");
        cfg_early = 1'b0;
        chk("early_rsp_data", 64'(host.rsp_data), 64'hBEEF);
        chk("early_rsp_addr", 64'(host.rsp_addr), 64'h8);

        repeat (5) @(negedge clk);
        chk("total_rsp_count", 64'(rsp_seen), 64'(rsp_expected));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
